// File: rtl/result_transmitter.sv
// Serialises two 64-bit result words into an 18-byte framed stream for a UART
// transmitter, issuing one byte per handshake with a one-cycle gap after each strobe.
module result_transmitter #(
  parameter logic [7:0] HEADER_BYTE = 8'd42,
  parameter logic [7:0] FOOTER_BYTE = 8'd42
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] word1,
  input  logic [63:0] word2,
  input  logic        send,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_new,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  localparam logic [4:0] LAST_INDEX = 5'd17;

  state_t       r_state;
  state_t       w_stateNext;
  logic [4:0]   r_index;
  logic [4:0]   w_indexNext;
  logic [63:0]  r_word1;
  logic [63:0]  r_word2;
  logic [63:0]  w_word1Next;
  logic [63:0]  w_word2Next;
  logic         w_txNew;
  logic         w_done;
  logic [127:0] w_payload;
  logic [3:0]   w_offset;
  logic [6:0]   w_bitSel;
  logic [7:0]   w_byte;

  // Payload bytes 1..16 map onto the concatenated words, least significant byte first.
  assign w_payload = {r_word2, r_word1};
  assign w_offset  = r_index[3:0] - 4'd1;
  assign w_bitSel  = {w_offset, 3'b000};

  always_comb begin
    if (r_index == 5'd0) begin
      w_byte = HEADER_BYTE;
    end else if (r_index == LAST_INDEX) begin
      w_byte = FOOTER_BYTE;
    end else begin
      w_byte = w_payload[w_bitSel +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_index <= 5'd0;
      r_word1 <= 64'd0;
      r_word2 <= 64'd0;
    end else begin
      r_state <= w_stateNext;
      r_index <= w_indexNext;
      r_word1 <= w_word1Next;
      r_word2 <= w_word2Next;
    end
  end

  // The GAP state gives the UART one cycle to raise tx_busy before SEND looks at it again.
  always_comb begin
    w_stateNext = r_state;
    w_indexNext = r_index;
    w_word1Next = r_word1;
    w_word2Next = r_word2;
    w_txNew     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (send) begin
          w_word1Next = word1;
          w_word2Next = word2;
          w_indexNext = 5'd0;
          w_stateNext = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          w_txNew     = 1'b1;
          w_stateNext = GAP;
        end
      end
      GAP: begin
        if (r_index == LAST_INDEX) begin
          w_done      = 1'b1;
          w_stateNext = IDLE;
        end else begin
          w_indexNext = r_index + 5'd1;
          w_stateNext = SEND;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign tx_data = w_byte;
  assign tx_new  = w_txNew;
  assign done    = w_done;
  assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_result_transmitter.sv
// Self-checking bench for result_transmitter: randomized frames compared against a
// byte-list model of the frame, with an optional UART busy model.
module tb_result_transmitter;

  logic        clk;
  logic        rst;
  logic [63:0] word1;
  logic [63:0] word2;
  logic        send;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_new;
  logic        busy;
  logic        done;
  logic [7:0]  tx_data2;
  logic        tx_new2;
  logic        busy2;
  logic        done2;

  int checks = 0;
  int failures = 0;
  int cycleNo = 0;
  int sendCycle = 0;
  int violations = 0;
  bit uartMode = 0;
  int busyCount = 0;
  bit prevTxNew = 0;
  logic prevBusy = 1'b0;

  logic [7:0] gotBytes[$];
  int         gotCycles[$];
  logic [7:0] gotBytes2[$];
  int         doneCycles[$];
  int         doneCycles2[$];
  int         busyFallCycles[$];
  logic [7:0] expFrame[18];

  result_transmitter dut (
    .clk(clk), .rst(rst), .word1(word1), .word2(word2), .send(send),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_new(tx_new), .busy(busy), .done(done)
  );

  result_transmitter #(.HEADER_BYTE(8'hA5), .FOOTER_BYTE(8'h5A)) dut2 (
    .clk(clk), .rst(rst), .word1(word1), .word2(word2), .send(send),
    .tx_busy(tx_busy), .tx_data(tx_data2), .tx_new(tx_new2), .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleNo++;

  // Passive observer: records strobes, completions and protocol violations mid-cycle.
  always @(negedge clk) begin
    if (tx_new === 1'b1) begin
      gotBytes.push_back(tx_data);
      gotCycles.push_back(cycleNo);
      if (prevTxNew) violations++;
      if (done === 1'b1) violations++;
      if (tx_busy === 1'b1) violations++;
    end
    if (tx_new2 === 1'b1) gotBytes2.push_back(tx_data2);
    if (done === 1'b1) doneCycles.push_back(cycleNo);
    if (done2 === 1'b1) doneCycles2.push_back(cycleNo);
    if (prevBusy === 1'b1 && busy === 1'b0) busyFallCycles.push_back(cycleNo);
    prevTxNew = (tx_new === 1'b1);
    prevBusy  = busy;
  end

  function automatic void buildFrame(input logic [63:0] w1, input logic [63:0] w2,
                                     input logic [7:0] hdr, input logic [7:0] ftr);
    expFrame[0] = hdr;
    for (int i = 0; i < 8; i++) begin
      expFrame[1 + i] = w1[8*i +: 8];
      expFrame[9 + i] = w2[8*i +: 8];
    end
    expFrame[17] = ftr;
  endfunction

  function automatic logic [63:0] randWord();
    return {$urandom, $urandom};
  endfunction

  task automatic clearLogs();
    gotBytes.delete();
    gotCycles.delete();
    gotBytes2.delete();
    doneCycles.delete();
    doneCycles2.delete();
    busyFallCycles.delete();
    violations = 0;
  endtask

  // Advances one cycle; the UART model holds tx_busy high for 10 cycles after each strobe.
  task automatic stepCycle();
    @(posedge clk);
    #1;
    if (uartMode) begin
      if (prevTxNew) busyCount = 10;
      tx_busy = (busyCount > 0);
      if (busyCount > 0) busyCount--;
    end else begin
      busyCount = 0;
      tx_busy = 1'b0;
    end
  endtask

  task automatic sendFrame(input logic [63:0] w1, input logic [63:0] w2);
    word1 = w1;
    word2 = w2;
    send = 1'b1;
    sendCycle = cycleNo;
    stepCycle();
    send = 1'b0;
  endtask

  task automatic waitBytes(input int n, input int budget, output bit timedOut);
    timedOut = 1'b1;
    for (int i = 0; i < budget; i++) begin
      stepCycle();
      if (gotBytes.size() >= n) begin
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  task automatic waitFrameEnd(input int nDone, input int budget, output bit timedOut);
    timedOut = 1'b1;
    for (int i = 0; i < budget; i++) begin
      stepCycle();
      if (doneCycles.size() >= nDone && busy === 1'b0) begin
        timedOut = 1'b0;
        break;
      end
    end
    stepCycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    send = 1'b0;
    tx_busy = 1'b0;
    word1 = 64'd0;
    word2 = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (tx_new !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx_new got=%b exp=0", tx_new); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    checks++;
    if (tx_data !== 8'h2A) begin failures++; $display("[TB] FAIL reset_tx_data got=%h exp=2a", tx_data); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic_frame();
    bit to;
    logic [7:0] g;
    stepCycle();
    clearLogs();
    buildFrame(64'h0807060504030201, 64'h100F0E0D0C0B0A09, 8'h2A, 8'h2A);
    sendFrame(64'h0807060504030201, 64'h100F0E0D0C0B0A09);
    waitFrameEnd(1, 80, to);
    checks++;
    if (to) begin failures++; $display("[TB] FAIL basic_timeout got=timeout exp=done"); end
    checks++;
    if (gotBytes.size() != 18) begin failures++; $display("[TB] FAIL basic_count got=%0d exp=18", gotBytes.size()); end
    for (int k = 0; k < 18; k++) begin
      g = (k < gotBytes.size()) ? gotBytes[k] : 8'hxx;
      checks++;
      if (g !== expFrame[k]) begin failures++; $display("[TB] FAIL basic_byte%0d got=%h exp=%h", k, g, expFrame[k]); end
      if (k < gotCycles.size()) begin
        checks++;
        if (gotCycles[k] != sendCycle + 1 + 2*k) begin
          failures++;
          $display("[TB] FAIL basic_strobe_cycle%0d got=%0d exp=%0d", k, gotCycles[k], sendCycle + 1 + 2*k);
        end
      end
    end
    checks++;
    if (doneCycles.size() != 1 || doneCycles[0] != sendCycle + 36) begin
      failures++;
      $display("[TB] FAIL basic_done got_count=%0d exp_cycle=%0d", doneCycles.size(), sendCycle + 36);
    end
    checks++;
    if (busyFallCycles.size() != 1 || busyFallCycles[0] != sendCycle + 37) begin
      failures++;
      $display("[TB] FAIL basic_busy_fall got_count=%0d exp_cycle=%0d", busyFallCycles.size(), sendCycle + 37);
    end
    checks++;
    if (violations != 0) begin failures++; $display("[TB] FAIL basic_protocol got=%0d exp=0", violations); end
  endtask

  task automatic test_uart_busy();
    bit to;
    logic [63:0] w1, w2;
    logic [7:0] g;
    w1 = randWord();
    w2 = randWord();
    uartMode = 1'b1;
    stepCycle();
    clearLogs();
    buildFrame(w1, w2, 8'h2A, 8'h2A);
    sendFrame(w1, w2);
    waitFrameEnd(1, 400, to);
    checks++;
    if (to) begin failures++; $display("[TB] FAIL uart_timeout got=timeout exp=done"); end
    checks++;
    if (gotBytes.size() != 18) begin failures++; $display("[TB] FAIL uart_count got=%0d exp=18", gotBytes.size()); end
    for (int k = 0; k < 18; k++) begin
      g = (k < gotBytes.size()) ? gotBytes[k] : 8'hxx;
      checks++;
      if (g !== expFrame[k]) begin failures++; $display("[TB] FAIL uart_byte%0d got=%h exp=%h", k, g, expFrame[k]); end
    end
    checks++;
    if (gotCycles.size() > 0 && gotCycles[0] != sendCycle + 1) begin
      failures++;
      $display("[TB] FAIL uart_first_strobe got=%0d exp=%0d", gotCycles[0], sendCycle + 1);
    end
    for (int k = 1; k < gotCycles.size(); k++) begin
      checks++;
      if (gotCycles[k] - gotCycles[k-1] != 11) begin
        failures++;
        $display("[TB] FAIL uart_spacing%0d got=%0d exp=11", k, gotCycles[k] - gotCycles[k-1]);
      end
    end
    checks++;
    if (violations != 0) begin failures++; $display("[TB] FAIL uart_protocol got=%0d exp=0", violations); end
    uartMode = 1'b0;
    repeat (12) stepCycle();
  endtask

  task automatic test_send_ignored();
    bit to;
    logic [63:0] w1, w2;
    logic [7:0] g;
    w1 = randWord();
    w2 = randWord();
    stepCycle();
    clearLogs();
    buildFrame(w1, w2, 8'h2A, 8'h2A);
    sendFrame(w1, w2);
    waitBytes(5, 40, to);
    checks++;
    if (to) begin failures++; $display("[TB] FAIL ignore_wait got=timeout exp=5_bytes"); end
    send = 1'b1;
    word1 = ~w1;
    word2 = randWord();
    stepCycle();
    stepCycle();
    send = 1'b0;
    word1 = randWord();
    waitFrameEnd(1, 80, to);
    repeat (5) stepCycle();
    checks++;
    if (gotBytes.size() != 18) begin failures++; $display("[TB] FAIL ignore_count got=%0d exp=18", gotBytes.size()); end
    for (int k = 0; k < 18; k++) begin
      g = (k < gotBytes.size()) ? gotBytes[k] : 8'hxx;
      checks++;
      if (g !== expFrame[k]) begin failures++; $display("[TB] FAIL ignore_byte%0d got=%h exp=%h", k, g, expFrame[k]); end
    end
    checks++;
    if (doneCycles.size() != 1) begin failures++; $display("[TB] FAIL ignore_done_count got=%0d exp=1", doneCycles.size()); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL ignore_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    bit to;
    logic [63:0] a1, a2, b1, b2;
    logic [7:0] g;
    a1 = randWord();
    a2 = randWord();
    b1 = randWord();
    b2 = randWord();
    stepCycle();
    clearLogs();
    word1 = a1;
    word2 = a2;
    send = 1'b1;
    sendCycle = cycleNo;
    stepCycle();
    word1 = b1;
    word2 = b2;
    waitBytes(19, 100, to);
    send = 1'b0;
    checks++;
    if (to) begin failures++; $display("[TB] FAIL b2b_second_start got=timeout exp=byte19"); end
    waitFrameEnd(2, 100, to);
    checks++;
    if (gotBytes.size() != 36) begin failures++; $display("[TB] FAIL b2b_count got=%0d exp=36", gotBytes.size()); end
    buildFrame(a1, a2, 8'h2A, 8'h2A);
    for (int k = 0; k < 18; k++) begin
      g = (k < gotBytes.size()) ? gotBytes[k] : 8'hxx;
      checks++;
      if (g !== expFrame[k]) begin failures++; $display("[TB] FAIL b2b_a_byte%0d got=%h exp=%h", k, g, expFrame[k]); end
    end
    buildFrame(b1, b2, 8'h2A, 8'h2A);
    for (int k = 0; k < 18; k++) begin
      g = (18 + k < gotBytes.size()) ? gotBytes[18 + k] : 8'hxx;
      checks++;
      if (g !== expFrame[k]) begin failures++; $display("[TB] FAIL b2b_b_byte%0d got=%h exp=%h", k, g, expFrame[k]); end
    end
    checks++;
    if (doneCycles.size() != 2 || doneCycles[0] != sendCycle + 36 || doneCycles[1] != sendCycle + 73) begin
      failures++;
      $display("[TB] FAIL b2b_done got_count=%0d exp_cycles=%0d,%0d", doneCycles.size(), sendCycle + 36, sendCycle + 73);
    end
    checks++;
    if (gotCycles.size() < 19 || doneCycles.size() < 1 || gotCycles[18] != doneCycles[0] + 2) begin
      failures++;
      $display("[TB] FAIL b2b_restart_latency got_strobes=%0d exp_cycle=%0d", gotCycles.size(), sendCycle + 38);
    end
  endtask

  task automatic test_reset_midframe();
    bit to;
    logic [63:0] w1, w2;
    logic [7:0] g;
    w1 = randWord();
    w2 = randWord();
    stepCycle();
    clearLogs();
    sendFrame(w1, w2);
    waitBytes(10, 40, to);
    checks++;
    if (to) begin failures++; $display("[TB] FAIL rstmid_wait got=timeout exp=10_bytes"); end
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_new !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_tx_new got=%b exp=0", tx_new); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy got=%b exp=0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_done got=%b exp=0", done); end
    repeat (20) stepCycle();
    checks++;
    if (gotBytes.size() != 10) begin failures++; $display("[TB] FAIL rstmid_stray_bytes got=%0d exp=10", gotBytes.size()); end
    checks++;
    if (doneCycles.size() != 0) begin failures++; $display("[TB] FAIL rstmid_done_count got=%0d exp=0", doneCycles.size()); end
    w1 = randWord();
    w2 = randWord();
    clearLogs();
    buildFrame(w1, w2, 8'h2A, 8'h2A);
    sendFrame(w1, w2);
    waitFrameEnd(1, 80, to);
    checks++;
    if (gotBytes.size() != 18) begin failures++; $display("[TB] FAIL rstmid_fresh_count got=%0d exp=18", gotBytes.size()); end
    for (int k = 0; k < 18; k++) begin
      g = (k < gotBytes.size()) ? gotBytes[k] : 8'hxx;
      checks++;
      if (g !== expFrame[k]) begin failures++; $display("[TB] FAIL rstmid_fresh_byte%0d got=%h exp=%h", k, g, expFrame[k]); end
    end
  endtask

  task automatic test_header_override();
    bit to;
    logic [63:0] w1, w2;
    logic [7:0] g;
    w1 = randWord();
    w2 = randWord();
    stepCycle();
    clearLogs();
    buildFrame(w1, w2, 8'hA5, 8'h5A);
    sendFrame(w1, w2);
    waitFrameEnd(1, 80, to);
    checks++;
    if (gotBytes2.size() != 18) begin failures++; $display("[TB] FAIL override_count got=%0d exp=18", gotBytes2.size()); end
    for (int k = 0; k < 18; k++) begin
      g = (k < gotBytes2.size()) ? gotBytes2[k] : 8'hxx;
      checks++;
      if (g !== expFrame[k]) begin failures++; $display("[TB] FAIL override_byte%0d got=%h exp=%h", k, g, expFrame[k]); end
    end
    checks++;
    if (doneCycles2.size() != 1) begin failures++; $display("[TB] FAIL override_done_count got=%0d exp=1", doneCycles2.size()); end
    checks++;
    if (busy2 !== 1'b0) begin failures++; $display("[TB] FAIL override_busy_after got=%b exp=0", busy2); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_uart_busy();
    test_send_ignored();
    test_back_to_back();
    test_reset_midframe();
    test_header_override();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_transmitter.md
RESULT_TRANSMITTER -- requirements
Module: result_transmitter

Interface
REQ-001 Parameter HEADER_BYTE, default 8'd42, first byte of every frame.
REQ-002 Parameter FOOTER_BYTE, default 8'd42, last byte of every frame.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 word1  input  64  first payload word; sampled only on accepted send.
REQ-006 word2  input  64  second payload word; sampled only on accepted send.
REQ-007 send  input  1  request to transmit one frame; level-sampled each cycle.
REQ-008 tx_busy  input  1  UART transmitter busy; byte may be issued only while low.
REQ-009 tx_data  output  8  byte presented to UART transmitter.
REQ-010 tx_new  output  1  one-cycle strobe: tx_data valid, UART shall take it.
REQ-011 busy  output  1  high from accepted send until frame complete.
REQ-012 done  output  1  one-cycle pulse marking frame completion.

Function
REQ-013 Frame SHALL be 18 bytes: HEADER_BYTE, word1[7:0]..word1[63:56] (LSB byte first), word2[7:0]..word2[63:56], FOOTER_BYTE.
REQ-014 States SHALL be IDLE, SEND, GAP; 5-bit byte index 0..17 selects tx_data.
REQ-015 IDLE: send=1 SHALL latch word1/word2 into internal registers, clear index to 0, go to SEND next cycle.
REQ-016 IDLE: send=0 SHALL hold state; tx_new=0.
REQ-017 SEND: tx_busy=0 SHALL drive tx_new=1 with tx_data=byte[index] in that same cycle, then go to GAP.
REQ-018 SEND: tx_busy=1 SHALL hold SEND with tx_new=0; no timeout.
REQ-019 GAP: exactly one cycle, tx_new=0; lets UART raise tx_busy before it is resampled.
REQ-020 GAP with index<17: increment index, go to SEND.
REQ-021 GAP with index=17: done=1 this cycle, go to IDLE.
REQ-022 busy SHALL equal (state != IDLE); done and tx_new SHALL never be high together.
REQ-023 tx_new SHALL be high only in SEND; never two consecutive cycles.
REQ-024 send while busy=1 SHALL be ignored; latched words SHALL not change mid-frame even if word1/word2 inputs change.
REQ-025 send high in the IDLE cycle immediately after done SHALL start a new frame (back-to-back allowed).
REQ-026 tx_data outside SEND is don't-care but SHALL be byte[index] (no X) for determinism.
REQ-027 Latency: send accepted at cycle N, tx_busy held low -> tx_new at N+1, N+3, ..., N+35; done at N+36; busy low at N+37.

Reset
REQ-028 rst=1 SHALL force next state IDLE, index 0, latched words 0; tx_new=0, busy=0, done=0 from the cycle after rst sampled.
REQ-029 rst mid-frame SHALL abort frame without done; no further tx_new until a new send.
REQ-030 rst takes priority over send in the same cycle.

Verification
REQ-031 word1=64'h0807060504030201, word2=64'h100F0E0D0C0B0A09, send 1 cycle, tx_busy=0 -> tx_data sequence 2A,01..08,09..10,2A on 18 tx_new strobes 2 cycles apart; done once at N+36.
REQ-032 Model UART raising tx_busy for 10 cycles after each tx_new -> same 18-byte sequence, no tx_new while tx_busy=1, no byte lost or duplicated.
REQ-033 Pulse send again at byte 5 and change word1 mid-frame -> frame unchanged, no second frame started.
REQ-034 send held high continuously -> frames back-to-back, new frame's first tx_new one cycle after busy falls (done cycle + 2).
REQ-035 rst asserted after byte 9 issued -> tx_new, busy, done low next cycle; subsequent send yields complete fresh frame starting with 2A.
REQ-036 Override HEADER_BYTE=8'hA5, FOOTER_BYTE=8'h5A -> first byte A5, last byte 5A, payload unchanged.
